// File: rtl/nes_poll_scheduler.sv
// rtl/nes_poll_scheduler.sv - periodic NES controller poll sequencer with timeout and 2-sample debounce
module nes_poll_scheduler #(
  parameter int POLL_CYCLES    = 416667,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int CNT_W          = 19
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  output logic       o_read_buttons,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_update,
  output logic       o_timeout,
  output logic [7:0] o_timeout_count,
  output logic       o_busy
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] poll_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [7:0]       prev_sample;
  logic             tick;

  // Gated so a tick cannot slip through on the cycle enable is dropped.
  assign tick = i_enable && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      poll_cnt <= '0;
    end else if (!i_enable || poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      to_cnt          <= '0;
      prev_sample     <= '0;
      o_read_buttons  <= 1'b0;
      o_buttons       <= '0;
      o_pressed       <= '0;
      o_released      <= '0;
      o_update        <= 1'b0;
      o_timeout       <= 1'b0;
      o_timeout_count <= '0;
      o_busy          <= 1'b0;
    end else begin
      o_read_buttons <= 1'b0;
      o_pressed      <= '0;
      o_released     <= '0;
      o_update       <= 1'b0;
      o_timeout      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state          <= S_REQUEST;
            o_read_buttons <= 1'b1;
            o_busy         <= 1'b1;
          end
        end
        S_REQUEST: begin
          state  <= S_WAIT;
          to_cnt <= '0;
        end
        S_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (i_valid) begin
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            prev_sample <= i_buttons;
            // Commit only when two consecutive samples agree and differ from the published state.
            if (i_buttons == prev_sample && i_buttons != o_buttons) begin
              o_buttons  <= i_buttons;
              o_pressed  <= i_buttons & ~o_buttons;
              o_released <= ~i_buttons & o_buttons;
              o_update   <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state     <= S_IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
            if (o_timeout_count != 8'hFF) begin
              o_timeout_count <= o_timeout_count + 8'd1;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// tb/tb_nes_poll_scheduler.sv - randomized + directed bench with time-window reference model
module tb_nes_poll_scheduler;

  localparam int POLL = 16;
  localparam int TMO  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] btn = 8'h00;

  logic       o_read_buttons, o_update, o_timeout, o_busy;
  logic [7:0] o_buttons, o_pressed, o_released, o_timeout_count;

  nes_poll_scheduler #(
    .POLL_CYCLES(POLL),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .i_enable(en),
    .o_read_buttons(o_read_buttons),
    .i_valid(valid),
    .i_buttons(btn),
    .o_buttons(o_buttons),
    .o_pressed(o_pressed),
    .o_released(o_released),
    .o_update(o_update),
    .o_timeout(o_timeout),
    .o_timeout_count(o_timeout_count),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: requests are tracked by the cycle they were issued; the
  // response window is the TMO cycles that follow, expiry reported right after.
  int         m_age = 0;
  int         m_cyc = 0;
  int         m_start = 0;
  bit         m_in_txn = 1'b0;
  int         m_tcount = 0;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_stable = 8'h00;
  logic [7:0] e_pressed = 8'h00;
  logic [7:0] e_released = 8'h00;
  bit         e_read = 1'b0;
  bit         e_update = 1'b0;
  bit         e_timeout = 1'b0;
  bit         e_busy = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_age = 0; m_cyc = 0; m_start = 0; m_in_txn = 0; m_tcount = 0;
        m_prev = 8'h00; m_stable = 8'h00; e_pressed = 8'h00; e_released = 8'h00;
        e_read = 0; e_update = 0; e_timeout = 0; e_busy = 0;
      end else begin
        bit tick;
        e_read = 0; e_update = 0; e_timeout = 0; e_pressed = 8'h00; e_released = 8'h00;
        tick = en && ((m_age % POLL) == POLL - 1);
        m_age = en ? m_age + 1 : 0;
        if (m_in_txn) begin
          if (m_cyc > m_start) begin
            if (valid) begin
              if (btn == m_prev && btn != m_stable) begin
                e_update   = 1;
                e_pressed  = btn & ~m_stable;
                e_released = ~btn & m_stable;
                m_stable   = btn;
              end
              m_prev   = btn;
              m_in_txn = 0;
            end else if (m_cyc - m_start == TMO) begin
              e_timeout = 1;
              m_tcount  = (m_tcount < 255) ? m_tcount + 1 : 255;
              m_in_txn  = 0;
            end
          end
        end else if (tick) begin
          m_in_txn = 1;
          m_start  = m_cyc + 1;
          e_read   = 1;
        end
        e_busy = m_in_txn;
        m_cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("read", int'(o_read_buttons), int'(e_read));
      chk("update", int'(o_update), int'(e_update));
      chk("timeout", int'(o_timeout), int'(e_timeout));
      chk("busy", int'(o_busy), int'(e_busy));
      chk("buttons", int'(o_buttons), int'(m_stable));
      chk("pressed", int'(o_pressed), int'(e_pressed));
      chk("released", int'(o_released), int'(e_released));
      chk("tmo_count", int'(o_timeout_count), m_tcount);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      n++;
      if (o_read_buttons) return;
    end
    chk("wait_req_expired", 0, 1);
  endtask

  // Called just after a request is seen; d==0 means never answer.
  task automatic respond(input logic [7:0] s, input int d);
    if (d == 0) begin
      step(TMO + 1);
    end else begin
      step(d);
      valid = 1'b1;
      btn   = s;
      step(1);
      valid = 1'b0;
      btn   = 8'($urandom);
    end
  endtask

  task automatic do_poll(input logic [7:0] s, input int d);
    int n;
    wait_req(n);
    respond(s, d);
  endtask

  initial begin
    int n;
    int reads;
    logic [7:0] last;
    step(3);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_buttons", int'(o_buttons), 0);
    chk("rst_tmo_count", int'(o_timeout_count), 0);
    rst_n = 1'b1;
    step(2);
    en = 1'b1;

    wait_req(n);
    chk("first_req_latency", n, 16);
    respond(8'h00, 5);
    chk("poll0_no_update", int'(o_update), 0);
    wait_req(n);
    chk("req_period", n, 10);
    respond(8'h01, 5);
    chk("poll1_no_update", int'(o_update), 0);
    do_poll(8'h01, 5);
    chk("press_update", int'(o_update), 1);
    chk("press_pressed", int'(o_pressed), 8'h01);
    chk("press_released", int'(o_released), 0);
    chk("press_buttons", int'(o_buttons), 8'h01);
    step(1);
    chk("press_pulse_width", int'(o_pressed), 0);

    do_poll(8'h01, 3);
    chk("same_no_update", int'(o_update), 0);
    do_poll(8'h81, 3);
    chk("glitch_a_no_update", int'(o_update), 0);
    do_poll(8'h01, 3);
    chk("glitch_b_no_update", int'(o_update), 0);
    chk("glitch_buttons", int'(o_buttons), 8'h01);
    do_poll(8'h00, 3);
    chk("release_first_no_update", int'(o_update), 0);
    do_poll(8'h00, 3);
    chk("release_update", int'(o_update), 1);
    chk("release_released", int'(o_released), 8'h01);
    chk("release_buttons", int'(o_buttons), 0);

    wait_req(n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n++;
      if (o_timeout) break;
    end
    chk("timeout_latency", n, TMO + 1);
    chk("timeout_count1", int'(o_timeout_count), 1);
    chk("timeout_buttons_kept", int'(o_buttons), 0);

    do_poll(8'h42, TMO);
    chk("expiry_race_no_timeout", int'(o_timeout), 0);
    chk("expiry_race_count", int'(o_timeout_count), 1);
    do_poll(8'h42, TMO);
    chk("expiry_race_captured", int'(o_buttons), 8'h42);
    do_poll(8'h13, TMO + 1);
    do_poll(8'h13, 3);
    chk("idle_valid_ignored", int'(o_update), 0);
    chk("idle_valid_count", int'(o_timeout_count), 2);

    for (int i = 0; i < 300; i++) do_poll(8'h00, 0);
    chk("timeout_saturate", int'(o_timeout_count), 255);

    last = 8'h00;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] s;
      case ($urandom_range(0, 3))
        0: s = 8'h00;
        1: s = 8'h81;
        2: s = last;
        default: s = 8'($urandom);
      endcase
      last = s;
      do_poll(s, int'($urandom_range(0, 10)));
      if ($urandom_range(0, 3) == 0) begin
        valid = 1'b1;
        btn   = 8'($urandom);
        step(1);
        valid = 1'b0;
      end
    end

    wait_req(n);
    step(2);
    en = 1'b0;
    step(3);
    valid = 1'b1;
    btn   = 8'h24;
    step(1);
    valid = 1'b0;
    chk("disable_busy_done", int'(o_busy), 0);
    reads = 0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      if (o_read_buttons) reads++;
    end
    chk("disable_no_requests", reads, 0);

    en = 1'b1;
    do_poll(8'h81, 4);
    do_poll(8'h81, 4);
    chk("pre_reset_buttons", int'(o_buttons), 8'h81);
    wait_req(n);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_buttons", int'(o_buttons), 0);
    chk("async_rst_busy", int'(o_busy), 0);
    chk("async_rst_count", int'(o_timeout_count), 0);
    chk("async_rst_read", int'(o_read_buttons), 0);
    step(2);
    rst_n = 1'b1;
    wait_req(n);
    chk("post_reset_latency", n, 16);
    respond(8'h00, 2);
    step(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
